// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and shared helpers for mult_div_unit.
package muldiv_pkg;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;
    localparam logic [63:0] DIV0_LO = '1;

    typedef enum logic [1:0] {IDLE, RUN, ADJ, DONE} state_t;

    function automatic logic is_signed_op(input logic [2:0] o);
        return o == OP_MULT || o == OP_DIV || o == OP_MADD || o == OP_MSUB;
    endfunction

    function automatic logic is_div_op(input logic [2:0] o);
        return o == OP_DIV || o == OP_DIVU;
    endfunction

    function automatic logic is_mt_op(input logic [2:0] o);
        return o == OP_MTHI || o == OP_MTLO;
    endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: unsigned one-step-per-enable shift-add multiply / restoring divide.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               divide,
    input  logic [WIDTH-1:0]   init,
    input  logic [WIDTH-1:0]   m,
    output logic [2*WIDTH-1:0] acc
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_new;
    logic             ge;

    // Multiply keeps the multiplier in the low half; divide keeps {remainder, quotient}.
    assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m};
    assign rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign ge      = rem_sh >= {1'b0, m};
    assign rem_new = ge ? rem_sh[WIDTH-1:0] - m : rem_sh[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (load)
            acc <= {{WIDTH{1'b0}}, init};
        else if (step)
            acc <= divide ? {rem_new, acc[WIDTH-2:0], ge}
                          : {acc[0] ? sum : {1'b0, acc[2*WIDTH-1:WIDTH]}, acc[WIDTH-1:1]};
    end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS multiply/divide feeding the HI/LO register pair.
import muldiv_pkg::*;

module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic             busy,
    output logic             done,
    output logic             hilo_write,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int CW = $clog2(ITER + 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2:0]           op_r;
    logic [WIDTH-1:0]     a_r, b_r, hi_r, lo_r, am, bm;
    logic [WIDTH-1:0]     a_mag, b_mag, q, r;
    logic [2*WIDTH-1:0]   acc, prod_s, div_res, res;
    logic                 neg, rem_neg;

    assign hilo_write = done;
    assign a_mag = (is_signed_op(op) && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_signed_op(op) && b[WIDTH-1]) ? -b : b;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .load   (state == IDLE && start && !is_mt_op(op)),
        .step   (state == RUN),
        .divide (is_div_op(op_r)),
        .init   (is_div_op(op) ? a_mag : b_mag),
        .m      (is_div_op(op_r) ? bm : am),
        .acc    (acc)
    );

    always_comb begin
        neg     = is_signed_op(op_r) && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
        rem_neg = is_signed_op(op_r) && a_r[WIDTH-1];
        q       = acc[WIDTH-1:0];
        r       = acc[2*WIDTH-1:WIDTH];
        prod_s  = neg ? -acc : acc;
        // Divide by zero bypasses the sign fix-up so HI returns the raw dividend.
        div_res = (b_r == '0) ? {a_r, DIV0_LO[WIDTH-1:0]}
                              : {rem_neg ? -r : r, neg ? -q : q};
        res     = op_r == OP_MADD ? {hi_r, lo_r} + prod_s :
                  op_r == OP_MSUB ? {hi_r, lo_r} - prod_s :
                  is_div_op(op_r) ? div_res : prod_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    op_r <= op;
                    a_r  <= a;
                    b_r  <= b;
                    hi_r <= hi_in;
                    lo_r <= lo_in;
                    am   <= a_mag;
                    bm   <= b_mag;
                    cnt  <= '0;
                    busy <= 1'b1;
                    if (is_mt_op(op)) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        hi_out <= op == OP_MTHI ? a : hi_in;
                        lo_out <= op == OP_MTHI ? lo_in : a;
                    end else
                        state <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1))
                        state <= ADJ;
                end
                ADJ: begin
                    state            <= DONE;
                    done             <= 1'b1;
                    {hi_out, lo_out} <= res;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
